// File: rtl/alu_pkg.sv
// Shared encodings for the 64-bit ALU and its issue front-end:
// ALU control codes, ALUOp field values and issue FSM states.
package alu_pkg;

    localparam int REG_WIDTH_DEF = 64;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALU_OP_MEM    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_RTYPE  = 2'b10,
        ALU_OP_ITYPE  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl_dec.sv
// Combinational decode of {ALUOp, funct3, funct7[5]} into the ALU control
// code plus branch sense and an illegal-encoding flag.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output alu_ctrl_t   alu_control,
    output logic        is_branch,
    output logic        branch_ne,
    output logic        illegal
);

    alu_ctrl_t arith_ctrl;
    logic      arith_illegal;

    // Shared R/I-type table; funct7_5 only qualifies 000 (R-type) and 101.
    always_comb begin
        arith_ctrl    = ALU_ADD;
        arith_illegal = 1'b0;
        unique case (funct3)
            3'b000: arith_ctrl = (alu_op == ALU_OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111: arith_ctrl = ALU_AND;
            3'b110: arith_ctrl = ALU_OR;
            3'b100: arith_ctrl = ALU_XOR;
            3'b001: arith_ctrl = ALU_SLL;
            3'b101: arith_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b010: arith_ctrl = ALU_SLT;
            3'b011: arith_ctrl = ALU_SLTU;
            default: arith_ctrl = ALU_ADD;
        endcase
        if (alu_op == ALU_OP_RTYPE)
            arith_illegal = funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101);
        else
            arith_illegal = funct7_5 && (funct3 == 3'b001);
    end

    always_comb begin
        alu_control = ALU_ADD;
        is_branch   = 1'b0;
        branch_ne   = 1'b0;
        illegal     = 1'b0;
        unique case (alu_op)
            ALU_OP_MEM: alu_control = ALU_ADD;
            ALU_OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    alu_control = ALU_SUB;
                    is_branch   = 1'b1;
                    branch_ne   = funct3[0];
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal     = arith_illegal;
                alu_control = arith_illegal ? ALU_ADD : arith_ctrl;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue/response front-end for the combinational ALU: accept, one registered
// execute cycle, then hold the captured response until the consumer takes it.
module alu_issue
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = REG_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_alu_op,
    input  logic [2:0]           req_funct3,
    input  logic                 req_funct7_5,
    input  logic [REG_WIDTH-1:0] req_in1,
    input  logic [REG_WIDTH-1:0] req_in2,
    output logic [REG_WIDTH-1:0] alu_in1,
    output logic [REG_WIDTH-1:0] alu_in2,
    output logic [3:0]           alu_control,
    input  logic [REG_WIDTH-1:0] alu_result,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [REG_WIDTH-1:0] rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_taken,
    output logic                 rsp_illegal,
    output logic [1:0]           dbg_state
);

    alu_ctrl_t dec_ctrl;
    logic      dec_branch;
    logic      dec_ne;
    logic      dec_illegal;

    alu_ctrl_dec u_dec (
        .alu_op      (alu_op_t'(req_alu_op)),
        .funct3      (req_funct3),
        .funct7_5    (req_funct7_5),
        .alu_control (dec_ctrl),
        .is_branch   (dec_branch),
        .branch_ne   (dec_ne),
        .illegal     (dec_illegal)
    );

    issue_state_t         state_q;
    logic [REG_WIDTH-1:0] in1_q, in2_q, result_q;
    alu_ctrl_t            ctrl_q;
    logic                 branch_q, ne_q, illegal_q;
    logic                 zero_q, taken_q, rsp_illegal_q;

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid never depends on ready, and req_* are ignored unless
    // req_ready is high.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= ST_IDLE;
            in1_q         <= '0;
            in2_q         <= '0;
            ctrl_q        <= ALU_AND;
            branch_q      <= 1'b0;
            ne_q          <= 1'b0;
            illegal_q     <= 1'b0;
            result_q      <= '0;
            zero_q        <= 1'b0;
            taken_q       <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        in1_q     <= req_in1;
                        in2_q     <= req_in2;
                        ctrl_q    <= dec_ctrl;
                        branch_q  <= dec_branch;
                        ne_q      <= dec_ne;
                        illegal_q <= dec_illegal;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q      <= alu_result;
                    zero_q        <= alu_zero;
                    taken_q       <= branch_q & (ne_q ? ~alu_zero : alu_zero);
                    rsp_illegal_q <= illegal_q;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_control = ctrl_q;
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign rsp_taken   = taken_q;
    assign rsp_illegal = rsp_illegal_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU closing the loop.
module tb_alu_issue;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset_b = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_alu_op = '0;
    logic [2:0]   req_funct3 = '0;
    logic         req_funct7_5 = 1'b0;
    logic [W-1:0] req_in1 = '0;
    logic [W-1:0] req_in2 = '0;
    logic [W-1:0] alu_in1, alu_in2;
    logic [3:0]   alu_control;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic         rsp_zero, rsp_taken, rsp_illegal;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue #(.REG_WIDTH(W)) dut (
        .clk(clk), .reset_b(reset_b),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7_5(req_funct7_5),
        .req_in1(req_in1), .req_in2(req_in2),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal),
        .dbg_state(dbg_state)
    );

    // Behavioural ALU
    always_comb begin
        alu_result = '0;
        case (alu_control)
            4'b0000: alu_result = alu_in1 & alu_in2;
            4'b0001: alu_result = alu_in1 | alu_in2;
            4'b0010: alu_result = alu_in1 + alu_in2;
            4'b0011: alu_result = alu_in1 ^ alu_in2;
            4'b0100: alu_result = alu_in1 << alu_in2[5:0];
            4'b0101: alu_result = alu_in1 >> alu_in2[5:0];
            4'b0110: alu_result = alu_in1 - alu_in2;
            4'b0111: alu_result = {63'd0, $signed(alu_in1) < $signed(alu_in2)};
            4'b1000: alu_result = $signed(alu_in1) >>> alu_in2[5:0];
            4'b1001: alu_result = {63'd0, alu_in1 < alu_in2};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        req_alu_op = op; req_funct3 = f3; req_funct7_5 = f7;
        req_in1 = a; req_in2 = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_tests++; if ({alu_in1, alu_in2, alu_control} !== '0) begin n_fail++; $display("FAIL reset_alu_outs got %h/%h/%h exp 0", alu_in1, alu_in2, alu_control); end
        n_tests++; if ({rsp_result, rsp_zero, rsp_taken, rsp_illegal} !== '0) begin n_fail++; $display("FAIL reset_rsp_outs got %h %b%b%b exp 0", rsp_result, rsp_zero, rsp_taken, rsp_illegal); end
        n_tests++; if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b exp 00", dbg_state); end
        @(negedge clk); reset_b = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        int cyc;
        send(2'b10, 3'b000, 1'b1, 64'd10, 64'd3);
        n_tests++; if (alu_control !== 4'b0110) begin n_fail++; $display("FAIL sub_ctrl got %b exp 0110", alu_control); end
        n_tests++; if (alu_in1 !== 64'd10 || alu_in2 !== 64'd3) begin n_fail++; $display("FAIL sub_operands got %0d,%0d exp 10,3", alu_in1, alu_in2); end
        n_tests++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sub_exec_flags got rdy=%b vld=%b exp 0,0", req_ready, rsp_valid); end
        wait_rsp(cyc);
        n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL sub_latency got %0d exp 1", cyc); end
        n_tests++; if (rsp_result !== 64'd7 || rsp_zero !== 1'b0) begin n_fail++; $display("FAIL sub_result got %0d z=%b exp 7 z=0", rsp_result, rsp_zero); end
        n_tests++; if (rsp_illegal !== 1'b0 || rsp_taken !== 1'b0) begin n_fail++; $display("FAIL sub_flags got ill=%b tk=%b exp 0,0", rsp_illegal, rsp_taken); end
        finish_rsp();
        n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL sub_handshake got vld=%b rdy=%b exp 0,1", rsp_valid, req_ready); end
    endtask

    task automatic test_branch();
        int cyc;
        send(2'b01, 3'b000, 1'b0, 64'h55, 64'h55);
        n_tests++; if (alu_control !== 4'b0110) begin n_fail++; $display("FAIL beq_ctrl got %b exp 0110", alu_control); end
        wait_rsp(cyc);
        n_tests++; if (rsp_zero !== 1'b1 || rsp_taken !== 1'b1 || rsp_result !== '0) begin n_fail++; $display("FAIL beq got z=%b tk=%b r=%h exp 1,1,0", rsp_zero, rsp_taken, rsp_result); end
        finish_rsp();
        send(2'b01, 3'b001, 1'b0, 64'h55, 64'h55);
        wait_rsp(cyc);
        n_tests++; if (rsp_zero !== 1'b1 || rsp_taken !== 1'b0) begin n_fail++; $display("FAIL bne_eq got z=%b tk=%b exp 1,0", rsp_zero, rsp_taken); end
        finish_rsp();
        send(2'b01, 3'b001, 1'b0, 64'h55, 64'h54);
        wait_rsp(cyc);
        n_tests++; if (rsp_zero !== 1'b0 || rsp_taken !== 1'b1) begin n_fail++; $display("FAIL bne_ne got z=%b tk=%b exp 0,1", rsp_zero, rsp_taken); end
        finish_rsp();
        send(2'b01, 3'b100, 1'b0, 64'd1, 64'd1);
        n_tests++; if (alu_control !== 4'b0010) begin n_fail++; $display("FAIL br_ill_ctrl got %b exp 0010", alu_control); end
        wait_rsp(cyc);
        n_tests++; if (rsp_illegal !== 1'b1 || rsp_taken !== 1'b0 || rsp_result !== 64'd2) begin n_fail++; $display("FAIL br_ill got ill=%b tk=%b r=%0d exp 1,0,2", rsp_illegal, rsp_taken, rsp_result); end
        finish_rsp();
    endtask

    task automatic test_illegal();
        int cyc;
        send(2'b11, 3'b000, 1'b1, 64'd5, 64'd7);
        n_tests++; if (alu_control !== 4'b0010) begin n_fail++; $display("FAIL addi_ctrl got %b exp 0010", alu_control); end
        wait_rsp(cyc);
        n_tests++; if (rsp_illegal !== 1'b0 || rsp_result !== 64'd12) begin n_fail++; $display("FAIL addi got ill=%b r=%0d exp 0,12", rsp_illegal, rsp_result); end
        finish_rsp();
        send(2'b10, 3'b111, 1'b1, 64'hF0, 64'h0F);
        n_tests++; if (alu_control !== 4'b0010) begin n_fail++; $display("FAIL r_ill_ctrl got %b exp 0010", alu_control); end
        wait_rsp(cyc);
        n_tests++; if (rsp_illegal !== 1'b1 || rsp_result !== 64'hFF || rsp_taken !== 1'b0) begin n_fail++; $display("FAIL r_ill got ill=%b r=%h tk=%b exp 1,ff,0", rsp_illegal, rsp_result, rsp_taken); end
        finish_rsp();
        send(2'b11, 3'b001, 1'b1, 64'd1, 64'd2);
        wait_rsp(cyc);
        n_tests++; if (rsp_illegal !== 1'b1 || rsp_result !== 64'd3) begin n_fail++; $display("FAIL slli_ill got ill=%b r=%0d exp 1,3", rsp_illegal, rsp_result); end
        finish_rsp();
        send(2'b10, 3'b111, 1'b0, 64'hF0, 64'h3C);
        wait_rsp(cyc);
        n_tests++; if (rsp_illegal !== 1'b0 || rsp_result !== 64'h30) begin n_fail++; $display("FAIL and got ill=%b r=%h exp 0,30", rsp_illegal, rsp_result); end
        finish_rsp();
    endtask

    task automatic test_shift();
        int cyc;
        send(2'b10, 3'b101, 1'b1, 64'h8000_0000_0000_0000, 64'd4);
        n_tests++; if (alu_control !== 4'b1000) begin n_fail++; $display("FAIL sra_ctrl got %b exp 1000", alu_control); end
        wait_rsp(cyc);
        n_tests++; if (rsp_result !== 64'hF800_0000_0000_0000) begin n_fail++; $display("FAIL sra got %h exp f800000000000000", rsp_result); end
        finish_rsp();
        send(2'b10, 3'b101, 1'b0, 64'h8000_0000_0000_0000, 64'd4);
        n_tests++; if (alu_control !== 4'b0101) begin n_fail++; $display("FAIL srl_ctrl got %b exp 0101", alu_control); end
        wait_rsp(cyc);
        n_tests++; if (rsp_result !== 64'h0800_0000_0000_0000) begin n_fail++; $display("FAIL srl got %h exp 0800000000000000", rsp_result); end
        finish_rsp();
        send(2'b11, 3'b101, 1'b1, 64'h8000_0000_0000_0000, 64'd4);
        n_tests++; if (alu_control !== 4'b1000) begin n_fail++; $display("FAIL srai_ctrl got %b exp 1000", alu_control); end
        wait_rsp(cyc);
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int cyc;
        send(2'b00, 3'b010, 1'b0, 64'd100, 64'd23);
        wait_rsp(cyc);
        req_valid = 1'b1; req_in1 = 64'd999; req_in2 = 64'd1; req_alu_op = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd123 || req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d] got vld=%b r=%0d rdy=%b exp 1,123,0", i, rsp_valid, rsp_result, req_ready); end
            n_tests++; if (alu_in1 !== 64'd100 || alu_control !== 4'b0010) begin n_fail++; $display("FAIL bp_ignore[%0d] got in1=%0d ctrl=%b exp 100,0010", i, alu_in1, alu_control); end
        end
        req_valid = 1'b0;
        finish_rsp();
        n_tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got rdy=%b vld=%b exp 1,0", req_ready, rsp_valid); end
        send(2'b10, 3'b100, 1'b0, 64'hF0, 64'hFF);
        wait_rsp(cyc);
        n_tests++; if (rsp_result !== 64'h0F || cyc !== 1) begin n_fail++; $display("FAIL bp_next got %h cyc=%0d exp 0f,1", rsp_result, cyc); end
        finish_rsp();
    endtask

    task automatic test_ready_early();
        rsp_ready = 1'b1;
        send(2'b10, 3'b010, 1'b0, {W{1'b1}}, 64'd1);
        n_tests++; if (rsp_valid !== 1'b0 || dbg_state !== 2'b01) begin n_fail++; $display("FAIL early_exec got vld=%b st=%b exp 0,01", rsp_valid, dbg_state); end
        @(posedge clk); #1;
        n_tests++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd1) begin n_fail++; $display("FAIL early_rsp got vld=%b r=%0d exp 1,1", rsp_valid, rsp_result); end
        @(posedge clk); #1;
        n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL early_done got vld=%b rdy=%b exp 0,1", rsp_valid, req_ready); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        send(2'b00, 3'b000, 1'b0, 64'd40, 64'd2);
        wait_rsp(cyc);
        #2 reset_b = 1'b0;
        #1;
        n_tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_flags got rdy=%b vld=%b exp 1,0", req_ready, rsp_valid); end
        n_tests++; if ({rsp_result, rsp_zero, rsp_taken, rsp_illegal, alu_in1, alu_in2, alu_control} !== '0) begin n_fail++; $display("FAIL rst_resp_outs got r=%h in1=%h ctrl=%b exp 0", rsp_result, alu_in1, alu_control); end
        @(negedge clk); reset_b = 1'b1;
        send(2'b00, 3'b000, 1'b0, 64'd40, 64'd2);
        #2 reset_b = 1'b0;
        @(negedge clk); reset_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_exec_norsp[%0d] got %b exp 0", i, rsp_valid); end
        end
        send(2'b11, 3'b011, 1'b0, 64'd1, 64'd2);
        wait_rsp(cyc);
        n_tests++; if (cyc !== 1 || rsp_result !== 64'd1) begin n_fail++; $display("FAIL rst_after got r=%0d cyc=%0d exp 1,1", rsp_result, cyc); end
        finish_rsp();
    endtask

    initial begin
        test_reset();
        test_sub();
        test_branch();
        test_illegal();
        test_shift();
        test_backpressure();
        test_ready_early();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequential issue/response front-end for the 64-bit `alu`. It accepts an operation request with operands and RV64 decode fields (ALUOp, funct3, funct7[5]), and translates them into the 4-bit `alu_control` encoding. It drives the combinational ALU for one registered execute cycle, then captures `result`/`zero` into a held response with branch-taken and illegal flags. It sits between the decode stage and the ALU in the multi-cycle datapath.

## Interface
- `REG_WIDTH`, 64, operand/result width; equals the ALU and register-file width.
- `clk` input 1: single clock, rising edge.
- `reset_b` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_alu_op` input 2: ALUOp (00 mem, 01 branch, 10 R-type, 11 I-type ALU).
- `req_funct3` input 3: instruction funct3.
- `req_funct7_5` input 1: instruction bit 30.
- `req_in1`, `req_in2` input REG_WIDTH: operands.
- `alu_in1`, `alu_in2` output REG_WIDTH: registered operands to the ALU.
- `alu_control` output 4: registered ALU control.
- `alu_result` input REG_WIDTH: ALU `result`.
- `alu_zero` input 1: ALU `zero`.
- `rsp_valid` output 1: response held.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_result` output REG_WIDTH: captured result.
- `rsp_zero` output 1: captured zero flag.
- `rsp_taken` output 1: branch taken (BEQ/BNE only).
- `rsp_illegal` output 1: the decode fields were unsupported.

## Operation
- ALU control codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000, SLTU 1001.
  - Codes 1010–1111 are never driven.
- Decode by ALUOp:
  - 00: ADD.
  - 01: SUB. taken = `alu_zero` for funct3 000 and `~alu_zero` for funct3 001. Any other funct3 is illegal.
  - 10: funct3 000 → ADD/SUB (by funct7_5); 111 AND; 110 OR; 100 XOR; 001 SLL; 101 SRL/SRA (by funct7_5); 010 SLT; 011 SLTU. funct7_5=1 with any funct3 other than 000/101 is illegal.
  - 11: same as 10, except funct3 000 is always ADD (funct7_5 ignored). funct7_5 selects SRA only for 101. funct7_5=1 with 001 is illegal.
- Illegal requests still execute with ADD and return rsp_illegal=1, rsp_taken=0.
- rsp_taken is 0 for every ALUOp other than 01.
- FSM:
  - IDLE: req_ready=1. On req_valid, register operands, control, branch sense and illegal flag, then go to EXEC.
  - EXEC: the ALU evaluates the registered inputs. At the clock edge, capture alu_result/alu_zero, compute rsp_taken, and go to RESP.
  - RESP: rsp_valid=1 and all rsp_* outputs stable. On rsp_ready, go to IDLE.
- alu_in1/alu_in2/alu_control hold their last values outside EXEC; they change only on acceptance.

## Timing
- Reset (reset_b=0, asynchronous): state IDLE, req_ready=1, rsp_valid=0; every other output is 0.
- Reset asserted mid-EXEC or mid-RESP aborts the operation and discards the response; no response follows.
- Request accepted at edge N (req_valid & req_ready). EXEC occupies cycle N..N+1, and rsp_valid rises after edge N+1: two-edge latency.
- Response handshake completes at the edge where rsp_valid & rsp_ready. rsp_valid falls after that edge and req_ready rises in the same cycle.
- No back-to-back overlap: req_ready=0 in EXEC and RESP. Throughput is one operation per 3 cycles when rsp_ready is held at 1.
- rsp_ready held high before rsp_valid is legal and does not shorten latency.
- req_* may change freely while req_ready=0 and are ignored then.

## Structure
- Package `alu_pkg`: `alu_ctrl_t` (4-bit enum with the codes above), `alu_op_t` (2-bit enum), and the FSM state enum (IDLE, EXEC, RESP).
- The `alu` module itself is shared through the same package codes.
- One natural sub-module: `alu_ctrl_dec`, combinational decode of {alu_op, funct3, funct7_5} → {alu_control, is_branch, branch_ne, illegal}.

## Test plan
- Reset mid-RESP → all outputs return to 0 and req_ready=1 immediately (asynchronous); a later request completes normally.
- R-type SUB: alu_op=10, f3=000, f7_5=1, in1=10, in2=3 → alu_control=0110, rsp_result=7, rsp_zero=0, rsp_valid two edges after acceptance.
- BEQ: alu_op=01, f3=000, in1=in2=0x55 → rsp_zero=1, rsp_taken=1. BNE with the same operands → rsp_taken=0.
- I-type ADDI with f7_5=1 (alu_op=11, f3=000) → ADD, rsp_illegal=0. R-type f3=111 with f7_5=1 → rsp_illegal=1, result = in1+in2.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_* stable, req_ready=0 throughout, and new req_valid pulses are ignored. Release → handshake completes, then the next request is accepted.
- SRA vs SRL: in1=0x8000_0000_0000_0000, in2=4 → SRA gives 0xF800_0000_0000_0000 and SRL gives 0x0800_0000_0000_0000.
